irq_arbiter: RTL and testbench

- Interrupt controller placed directly in front of the fetch stage.
- Captures events from several requesters (key, ethernet, ...), latches them as pending, and applies per-source masks.
- Selects one source by fixed priority and issues a single-cycle take pulse that fetch uses to redirect to the handler.
- Blocks further takes until the handler returns via rti/rsi, and exposes the cause of the interrupt being serviced.

---
 rtl/irq_arbiter_if.sv | 28 ++
 rtl/irq_arbiter.sv | 112 +++++++++++
 tb/tb_irq_arbiter.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/irq_arbiter_if.sv
// Request/mask/return bundle between the interrupt arbiter and its surroundings.
// The master drives requests, mask writes and handler returns; the slave is the arbiter.
interface irq_arbiter_if #(
  parameter int NUM_SRC = 2,
  parameter int CAUSE_W = 2
);
  logic [NUM_SRC-1:0] irq_src;
  logic               mask_we;
  logic [NUM_SRC-1:0] mask_wdata;
  logic               branch;
  logic               rti;
  logic               rsi;
  logic               irq_take;
  logic [CAUSE_W-1:0] irq_cause;
  logic               in_service;
  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] mask;

  modport master (
    output irq_src, mask_we, mask_wdata, branch, rti, rsi,
    input  irq_take, irq_cause, in_service, pending, mask
  );

  modport slave (
    input  irq_src, mask_we, mask_wdata, branch, rti, rsi,
    output irq_take, irq_cause, in_service, pending, mask
  );
endinterface

// File: rtl/irq_arbiter.sv
// Fixed-priority interrupt arbiter in front of fetch: latches request edges, masks them,
// issues a one-cycle take pulse and blocks further takes until the handler returns.
module irq_arbiter #(
  parameter int NUM_SRC    = 2,
  parameter int CAUSE_W    = 2,
  parameter int GAP_CYCLES = 2
) (
  input logic         clk,
  input logic         rst,
  irq_arbiter_if.slave bus
);
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;

  typedef enum logic [1:0] {IDLE, TAKE, SERVICE, GAP} state_t;

  state_t             state, state_next;
  logic [NUM_SRC-1:0] prev;
  logic [NUM_SRC-1:0] pending, pending_next;
  logic [NUM_SRC-1:0] mask;
  logic [NUM_SRC-1:0] events;
  logic [NUM_SRC-1:0] eligible;
  logic [NUM_SRC-1:0] clr;
  logic [CAUSE_W-1:0] cause;
  logic [CAUSE_W-1:0] winner;
  logic               load_cause;
  logic [GAP_W-1:0]   gap_cnt, gap_next;

  assign events   = bus.irq_src & ~prev;
  assign eligible = pending & mask;
  // Set wins over clear so an event arriving during its own take is not lost.
  assign pending_next = (pending & ~clr) | events;

  always_comb begin
    winner = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        winner = CAUSE_W'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    gap_next   = gap_cnt;
    load_cause = 1'b0;
    clr        = '0;
    case (state)
      IDLE: begin
        if ((eligible != '0) && !bus.branch) begin
          state_next = TAKE;
          load_cause = 1'b1;
        end
      end
      TAKE: begin
        clr        = NUM_SRC'(1) << cause;
        state_next = SERVICE;
      end
      SERVICE: begin
        if (bus.rti || bus.rsi) begin
          if (GAP_CYCLES == 0) begin
            state_next = IDLE;
          end else begin
            state_next = GAP;
            gap_next   = GAP_W'(GAP_CYCLES);
          end
        end
      end
      GAP: begin
        // The counter value is the number of GAP cycles still to spend, this one included.
        gap_next = gap_cnt - GAP_W'(1);
        if (gap_cnt <= GAP_W'(1)) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev    <= bus.irq_src;
      pending <= '0;
      mask    <= '1;
      cause   <= '0;
      gap_cnt <= '0;
    end else begin
      prev    <= bus.irq_src;
      pending <= pending_next;
      gap_cnt <= gap_next;
      if (bus.mask_we) begin
        mask <= bus.mask_wdata;
      end
      if (load_cause) begin
        cause <= winner;
      end
    end
  end

  assign bus.irq_take   = (state == TAKE);
  assign bus.in_service = (state == SERVICE);
  assign bus.irq_cause  = cause;
  assign bus.pending    = pending;
  assign bus.mask       = mask;
endmodule

// File: tb/tb_irq_arbiter.sv
// Bench for irq_arbiter: directed scenarios plus random traffic, compared every cycle
// against a timestamp-based reference model of the interrupt rules.
module tb_irq_arbiter;
  localparam int NUM_SRC    = 2;
  localparam int CAUSE_W    = 2;
  localparam int GAP_CYCLES = 2;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  irq_arbiter_if #(.NUM_SRC(NUM_SRC), .CAUSE_W(CAUSE_W)) bus ();

  irq_arbiter #(.NUM_SRC(NUM_SRC), .CAUSE_W(CAUSE_W), .GAP_CYCLES(GAP_CYCLES)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int takes;

  // Model: handler activity is tracked as flags plus the first cycle a new take may be decided.
  logic [NUM_SRC-1:0] m_pending, m_mask, m_prev;
  logic               m_take, m_service;
  logic [CAUSE_W-1:0] m_cause;
  int                 m_idle_from = 0;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic step();
    logic [NUM_SRC-1:0] ev, clr, elig, n_pending, n_mask, n_prev;
    logic               n_take, n_service;
    logic [CAUSE_W-1:0] n_cause;
    int                 n_idle_from;
    if (rst) begin
      n_pending   = '0;
      n_mask      = '1;
      n_prev      = bus.irq_src;
      n_take      = 1'b0;
      n_service   = 1'b0;
      n_cause     = '0;
      n_idle_from = 0;
    end else begin
      ev          = bus.irq_src & ~m_prev;
      elig        = m_pending & m_mask;
      clr         = '0;
      n_take      = 1'b0;
      n_service   = m_service;
      n_cause     = m_cause;
      n_idle_from = m_idle_from;
      if (m_take) begin
        n_service    = 1'b1;
        clr[m_cause] = 1'b1;
      end else if (m_service) begin
        if (bus.rti || bus.rsi) begin
          n_service   = 1'b0;
          n_idle_from = cyc + 1 + GAP_CYCLES;
        end
      end else if (cyc >= m_idle_from && elig != '0 && !bus.branch) begin
        n_take = 1'b1;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
          if (elig[i]) n_cause = CAUSE_W'(i);
        end
      end
      n_pending = (m_pending & ~clr) | ev;
      n_mask    = bus.mask_we ? bus.mask_wdata : m_mask;
      n_prev    = bus.irq_src;
    end
    @(posedge clk);
    #1;
    m_pending   = n_pending;
    m_mask      = n_mask;
    m_prev      = n_prev;
    m_take      = n_take;
    m_service   = n_service;
    m_cause     = n_cause;
    m_idle_from = n_idle_from;
    cyc++;
    check_output("take", 32'(bus.irq_take), 32'(m_take));
    check_output("in_service", 32'(bus.in_service), 32'(m_service));
    check_output("pending", 32'(bus.pending), 32'(m_pending));
    check_output("mask", 32'(bus.mask), 32'(m_mask));
    if (m_take || m_service) begin
      check_output("cause", 32'(bus.irq_cause), 32'(m_cause));
    end
  endtask

  task automatic apply_stimulus(input logic [NUM_SRC-1:0] src, input logic br,
                                input logic ret_i, input logic ret_s,
                                input logic we, input logic [NUM_SRC-1:0] wdata);
    bus.irq_src    = src;
    bus.branch     = br;
    bus.rti        = ret_i;
    bus.rsi        = ret_s;
    bus.mask_we    = we;
    bus.mask_wdata = wdata;
    step();
  endtask

  task automatic return_from_handler();
    apply_stimulus(bus.irq_src, 1'b0, 1'b1, 1'b0, 1'b0, '0);
    repeat (GAP_CYCLES + 2) apply_stimulus(bus.irq_src, 1'b0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  initial begin
    rst = 1'b1;
    bus.irq_src = '0; bus.branch = 1'b0; bus.rti = 1'b0; bus.rsi = 1'b0;
    bus.mask_we = 1'b0; bus.mask_wdata = '0;

    // Reset state
    apply_stimulus(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    apply_stimulus(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    check_output("reset_cause", 32'(bus.irq_cause), 32'd0);
    check_output("reset_mask", 32'(bus.mask), 32'h3);
    rst = 1'b0;

    // Single edge on source 1: pending, take, service
    repeat (3) apply_stimulus(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    apply_stimulus(2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    check_output("s1_pending", 32'(bus.pending), 32'h2);
    apply_stimulus(2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    check_output("s1_take", 32'(bus.irq_take), 32'd1);
    check_output("s1_cause", 32'(bus.irq_cause), 32'd1);
    apply_stimulus(2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    check_output("s1_service", 32'(bus.in_service), 32'd1);
    check_output("s1_cleared", 32'(bus.pending), 32'd0);
    return_from_handler();

    // Simultaneous edges: priority order and return-to-take spacing
    apply_stimulus(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    apply_stimulus(2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    apply_stimulus(2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    check_output("s2_first_take", 32'(bus.irq_take), 32'd1);
    check_output("s2_first_cause", 32'(bus.irq_cause), 32'd0);
    repeat (10) apply_stimulus(2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    for (int i = 1; i <= 4; i++) begin
      apply_stimulus(2'b11, 1'b0, (i == 1), 1'b0, 1'b0, 2'b00);
      check_output("s2_gap_take", 32'(bus.irq_take), 32'(i == 4));
    end
    check_output("s2_second_cause", 32'(bus.irq_cause), 32'd1);
    apply_stimulus(2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    return_from_handler();

    // Masked source stays pending, unmasking makes it eligible
    apply_stimulus(2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10);
    apply_stimulus(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    apply_stimulus(2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    repeat (3) begin
      apply_stimulus(2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
      check_output("s3_masked_no_take", 32'(bus.irq_take), 32'd0);
    end
    check_output("s3_masked_pending", 32'(bus.pending), 32'h1);
    apply_stimulus(2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11);
    apply_stimulus(2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    check_output("s3_unmask_take", 32'(bus.irq_take), 32'd1);
    check_output("s3_unmask_cause", 32'(bus.irq_cause), 32'd0);
    apply_stimulus(2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    return_from_handler();

    // Branch held high defers the take
    apply_stimulus(2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
    check_output("s4_branch_no_take", 32'(bus.irq_take), 32'd0);
    apply_stimulus(2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
    check_output("s4_branch_no_take", 32'(bus.irq_take), 32'd0);
    apply_stimulus(2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
    check_output("s4_branch_no_take", 32'(bus.irq_take), 32'd0);
    check_output("s4_branch_pending", 32'(bus.pending), 32'h1);
    apply_stimulus(2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    check_output("s4_branch_release_take", 32'(bus.irq_take), 32'd1);
    apply_stimulus(2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    return_from_handler();

    // Level held high is one event only
    apply_stimulus(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    apply_stimulus(2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    repeat (18) apply_stimulus(2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    return_from_handler();
    takes = 0;
    repeat (6) begin
      apply_stimulus(2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
      takes += int'(bus.irq_take);
    end
    check_output("s5_no_retake", 32'(takes), 32'd0);
    check_output("s5_nothing_pending", 32'(bus.pending), 32'd0);
    apply_stimulus(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    apply_stimulus(2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    takes = 0;
    repeat (6) begin
      apply_stimulus(2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
      takes += int'(bus.irq_take);
    end
    check_output("s5_one_new_take", 32'(takes), 32'd1);
    return_from_handler();

    // Reset in the middle of a service
    apply_stimulus(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    apply_stimulus(2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    apply_stimulus(2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    apply_stimulus(2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    apply_stimulus(2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01);
    check_output("s6_pre_pending", 32'(bus.pending), 32'h1);
    check_output("s6_pre_service", 32'(bus.in_service), 32'd1);
    rst = 1'b1;
    apply_stimulus(2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    rst = 1'b0;
    check_output("s6_rst_service", 32'(bus.in_service), 32'd0);
    check_output("s6_rst_pending", 32'(bus.pending), 32'd0);
    check_output("s6_rst_mask", 32'(bus.mask), 32'h3);
    apply_stimulus(2'b11, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00);
    takes = 0;
    repeat (5) begin
      apply_stimulus(2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
      takes += int'(bus.irq_take);
    end
    check_output("s6_no_take_after_rsi", 32'(takes), 32'd0);

    // Random traffic against the model
    repeat (600) begin
      logic [NUM_SRC-1:0] src;
      src = bus.irq_src;
      for (int i = 0; i < NUM_SRC; i++) begin
        if ($urandom_range(3) == 0) src[i] = ~src[i];
      end
      rst = ($urandom_range(96) == 0);
      apply_stimulus(src, ($urandom_range(3) == 0), ($urandom_range(9) == 0),
                     ($urandom_range(11) == 0), ($urandom_range(15) == 0),
                     NUM_SRC'($urandom));
    end
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
